// File: rtl/man_tx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// man_tx_pkg : state encoding, framing constants and timing helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package man_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    FCS      = 3'd4,
    EOF      = 3'd5
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_PAT = 8'h55;
  localparam logic [7:0] SFD_DEFAULT  = 8'hD0;

  function automatic int half_count(input int clk_freq, input int bit_rate);
    return clk_freq / (2 * bit_rate);
  endfunction

  // Counter width that stays legal for tiny ranges.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/man_tx_halfbit_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// man_tx_halfbit_timer : free-running half-bit divider, held at 0 while idle
// Rev 1.0
// ---------------------------------------------------------------------------
module man_tx_halfbit_timer
  import man_tx_pkg::*;
#(
  parameter int HALF = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enb,
  output logic tick
);

  localparam int CW = ctr_width(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!enb) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/man_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// man_transmitter : framed Manchester serialiser (preamble, SFD, payload, EOF)
// Optional checksum byte after the payload when MAN_TX_FCS_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
module man_transmitter
  import man_tx_pkg::*;
#(
  parameter int         CLK_FREQ       = 100_000_000,
  parameter int         BIT_RATE       = 50000,
  parameter int         DATA_WIDTH     = 8,
  parameter int         PREAMBLE_BYTES = 2,
  parameter logic [7:0] SFD_BYTE       = SFD_DEFAULT,
  parameter int         EOF_BITS       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  input  logic                  last,
  output logic                  ready,
  output logic                  txd,
  output logic                  txen,
  output logic                  busy,
  output logic                  underrun
);

  localparam int HALF       = half_count(CLK_FREQ, BIT_RATE);
  localparam int SHW        = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
  localparam int BCW        = ctr_width(SHW);
  localparam int PBW        = ctr_width(PREAMBLE_BYTES);
  localparam int EOF_HALVES = 2 * EOF_BITS;
  localparam int ECW        = ctr_width(EOF_HALVES);

  tx_state_e             state_q, state_d;
  logic [SHW-1:0]        shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  phase_q, phase_d;
  logic [PBW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [ECW-1:0]        eof_cnt_q, eof_cnt_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] fcs_q, fcs_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_last_q, hold_last_d;
  logic                  hold_full_q, hold_full_d;
  logic                  txd_q, txd_d;
  logic                  txen_q, txen_d;
  logic                  underrun_q, underrun_d;

  logic                  tick;
  logic                  timer_en;
  logic                  take_hold;
  logic [BCW-1:0]        bit_end;

  assign timer_en = (state_q != IDLE);

  man_tx_halfbit_timer #(
    .HALF (HALF)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .enb   (timer_en),
    .tick  (tick)
  );

  assign ready    = !reset && !hold_full_q && (state_q != EOF);
  assign busy     = (state_q != IDLE);
  assign txd      = txd_q;
  assign txen     = txen_q;
  assign underrun = underrun_q;

  // Framing bytes are always 8 bits; payload and checksum use DATA_WIDTH.
  assign bit_end = ((state_q == PREAMBLE) || (state_q == SFD)) ? BCW'(7) : BCW'(DATA_WIDTH - 1);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    phase_d     = phase_q;
    byte_cnt_d  = byte_cnt_q;
    eof_cnt_d   = eof_cnt_q;
    last_d      = last_q;
    fcs_d       = fcs_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    txd_d       = txd_q;
    txen_d      = txen_q;
    underrun_d  = 1'b0;
    take_hold   = 1'b0;

    if (valid && ready) begin
      hold_d      = data;
      hold_last_d = last;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        txen_d = 1'b0;
        if (hold_full_q) begin
          state_d    = PREAMBLE;
          shift_d    = SHW'(PREAMBLE_PAT);
          bit_cnt_d  = '0;
          phase_d    = 1'b0;
          byte_cnt_d = '0;
          fcs_d      = '0;
          txd_d      = PREAMBLE_PAT[0];
          txen_d     = 1'b1;
        end
      end
      EOF: begin
        txd_d = 1'b1;
        if (tick) begin
          if (eof_cnt_q == ECW'(EOF_HALVES - 1)) begin
            state_d = IDLE;
            txen_d  = 1'b0;
          end else begin
            eof_cnt_d = eof_cnt_q + ECW'(1);
          end
        end
      end
      default: begin
        // First half carries the bit value, second half its complement.
        if (tick && !phase_q) begin
          phase_d = 1'b1;
          txd_d   = ~shift_q[0];
        end else if (tick && (bit_cnt_q != bit_end)) begin
          phase_d   = 1'b0;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          txd_d     = shift_q[1];
        end else if (tick) begin
          phase_d   = 1'b0;
          bit_cnt_d = '0;
          case (state_q)
            PREAMBLE: begin
              if (byte_cnt_q == PBW'(PREAMBLE_BYTES - 1)) begin
                state_d = SFD;
                shift_d = SHW'(SFD_BYTE);
                txd_d   = SFD_BYTE[0];
              end else begin
                byte_cnt_d = byte_cnt_q + PBW'(1);
                shift_d    = SHW'(PREAMBLE_PAT);
                txd_d      = PREAMBLE_PAT[0];
              end
            end
            SFD: begin
              state_d   = DATA;
              take_hold = 1'b1;
            end
            DATA: begin
              if (!last_q && hold_full_q) begin
                take_hold = 1'b1;
              end else begin
                underrun_d = !last_q;
`ifdef MAN_TX_FCS_EN
                state_d = FCS;
                shift_d = SHW'(fcs_q);
                txd_d   = fcs_q[0];
`else
                state_d   = EOF;
                eof_cnt_d = '0;
                txd_d     = 1'b1;
`endif
              end
            end
            default: begin
              state_d   = EOF;
              eof_cnt_d = '0;
              txd_d     = 1'b1;
            end
          endcase
        end
      end
    endcase

    if (take_hold) begin
      shift_d     = SHW'(hold_q);
      last_d      = hold_last_q;
      hold_full_d = 1'b0;
      fcs_d       = fcs_q ^ hold_q;
      txd_d       = hold_q[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      phase_q     <= 1'b0;
      byte_cnt_q  <= '0;
      eof_cnt_q   <= '0;
      last_q      <= 1'b0;
      fcs_q       <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      txen_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_q     <= phase_d;
      byte_cnt_q  <= byte_cnt_d;
      eof_cnt_q   <= eof_cnt_d;
      last_q      <= last_d;
      fcs_q       <= fcs_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      txen_q      <= txen_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_man_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_man_transmitter : self-checking bench, HALF = 10 clocks per half-bit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_man_transmitter;

  localparam int CLK_FREQ = 1000;
  localparam int BIT_RATE = 50;
  localparam int HALF_T   = 10;
  localparam int PRE      = 2;
  localparam int EOFB     = 2;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, txd, txen, busy, underrun;

  int total = 0;
  int bad   = 0;
  int ready_rises = 0;
  bit exp_h[$];

  man_transmitter #(
    .CLK_FREQ (CLK_FREQ),
    .BIT_RATE (BIT_RATE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .valid    (valid),
    .last     (last),
    .ready    (ready),
    .txd      (txd),
    .txen     (txen),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Reference: expected txd per half-bit for a whole frame.
  function automatic void build_exp(input bq_t pl);
    bq_t        fr;
    logic [7:0] x;
    logic [7:0] b;
    x  = 8'h00;
    fr = {};
    for (int i = 0; i < PRE; i++) fr.push_back(8'h55);
    fr.push_back(8'hD0);
    foreach (pl[i]) begin
      fr.push_back(pl[i]);
      x = x ^ pl[i];
    end
`ifdef MAN_TX_FCS_EN
    fr.push_back(x);
`endif
    exp_h = {};
    foreach (fr[i]) begin
      b = fr[i];
      for (int k = 0; k < 8; k++) begin
        exp_h.push_back(b[k]);
        exp_h.push_back(!b[k]);
      end
    end
    for (int k = 0; k < 2 * EOFB; k++) exp_h.push_back(1'b1);
  endfunction

  task automatic drive(input bq_t pl, input bit tag_last);
    for (int i = 0; i < pl.size(); i++) begin
      int w;
      w     = 0;
      data  = pl[i];
      last  = tag_last && (i == pl.size() - 1);
      valid = 1'b1;
      while (ready !== 1'b1 && w < 5000) begin
        @(negedge clk);
        w++;
      end
      if (ready !== 1'b1) begin
        total++;
        bad++;
        $display("FAIL drive_timeout: ready=%b after %0d cycles, required 1", ready, w);
        valid = 1'b0;
        last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int under_at, output int lead);
    int   tot, ucnt, upos, rises;
    logic prev_rdy;
    tot   = exp_h.size();
    lead  = 0;
    ucnt  = 0;
    upos  = -1;
    rises = 0;
    while (txen !== 1'b1 && lead < 2000) begin
      @(negedge clk);
      lead++;
    end
    total++;
    if (txen !== 1'b1) begin
      bad++;
      $display("FAIL %s_start: txen=%b after %0d cycles, required 1", nm, txen, lead);
      ready_rises = -1;
      return;
    end
    prev_rdy = ready;
    for (int n = 0; n <= tot * HALF_T; n++) begin
      if (n > 0) @(negedge clk);
      if (n < tot * HALF_T) begin
        if (n % HALF_T == HALF_T / 2) begin
          total++;
          if (txd !== exp_h[n / HALF_T]) begin
            bad++;
            $display("FAIL %s_txd half %0d: got %b, required %b", nm, n / HALF_T, txd, exp_h[n / HALF_T]);
          end
        end
        if (ready === 1'b1 && prev_rdy !== 1'b1) rises++;
        prev_rdy = ready;
        if (underrun === 1'b1) begin
          ucnt++;
          upos = n;
        end
      end
      if (n == tot * HALF_T - 1) begin
        total++;
        if (txen !== 1'b1) begin
          bad++;
          $display("FAIL %s_txen_hold: got %b, required 1", nm, txen);
        end
      end
      if (n == tot * HALF_T) begin
        total++;
        if (txen !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL %s_end: txen=%b busy=%b, required 0 0", nm, txen, busy);
        end
      end
    end
    total++;
    if ((under_at < 0) ? (ucnt != 0) : (ucnt != 1 || upos != under_at)) begin
      bad++;
      $display("FAIL %s_underrun: pulses=%0d at %0d, required %0d at %0d",
               nm, ucnt, upos, (under_at < 0) ? 0 : 1, under_at);
    end
    ready_rises = rises;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (txd !== 1'b1 || txen !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_line: txd=%b txen=%b busy=%b, required 1 0 0", txd, txen, busy);
    end
    total++;
    if (ready !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: ready=%b underrun=%b, required 0 0", ready, underrun);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle: ready=%b busy=%b txd=%b, required 1 0 1", ready, busy, txd);
    end
  endtask

  task automatic test_single();
    bq_t pl;
    int  lead;
    pl = {8'hA5};
    build_exp(pl);
    fork
      drive(pl, 1'b1);
      check_frame("single", -1, lead);
    join
    total++;
    if (lead != 2) begin
      bad++;
      $display("FAIL single_latency: txen after %0d cycles, required 2", lead);
    end
  endtask

  task automatic test_stream();
    bq_t pl;
    int  lead;
    pl = {8'h11, 8'h22, 8'h33};
    build_exp(pl);
    fork
      drive(pl, 1'b1);
      check_frame("stream", -1, lead);
    join
    total++;
    if (ready_rises != 3) begin
      bad++;
      $display("FAIL stream_ready: rises=%0d, required 3", ready_rises);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      bq_t pl;
      int  n, lead;
      pl = {};
      n  = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      build_exp(pl);
      fork
        drive(pl, 1'b1);
        check_frame("random", -1, lead);
      join
    end
  endtask

  task automatic test_underrun();
    bq_t pl;
    int  lead;
    pl = {8'($urandom), 8'($urandom)};
    build_exp(pl);
    fork
      drive(pl, 1'b0);
      check_frame("underrun", (PRE + 1 + 2) * 16 * HALF_T, lead);
    join
  endtask

  task automatic test_reset_in_sfd();
    bq_t pl;
    int  w, lead;
    pl = {8'h5A};
    drive(pl, 1'b1);
    w = 0;
    while (txen !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat ((PRE * 16 + 5) * HALF_T) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (txd !== 1'b1 || txen !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sfd_reset: txd=%b txen=%b busy=%b, required 1 0 0", txd, txen, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3 * HALF_T) @(negedge clk);
    total++;
    if (txd !== 1'b1 || txen !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sfd_after: txd=%b txen=%b busy=%b, required 1 0 0", txd, txen, busy);
    end
    pl = {8'($urandom), 8'($urandom)};
    build_exp(pl);
    fork
      drive(pl, 1'b1);
      check_frame("sfd_restart", -1, lead);
    join
  endtask

  task automatic test_back_to_back();
    bq_t pa, pb;
    int  la, lb;
    pa = {8'($urandom), 8'($urandom)};
    pb = {8'($urandom)};
    lb = -1;
    fork
      begin
        drive(pa, 1'b1);
        drive(pb, 1'b1);
      end
      begin
        build_exp(pa);
        check_frame("b2b_a", -1, la);
        build_exp(pb);
        check_frame("b2b_b", -1, lb);
      end
    join
    total++;
    if (lb != 1) begin
      bad++;
      $display("FAIL b2b_gap: next frame after %0d cycles, required 1", lb);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_stream();
    test_random();
    test_underrun();
    test_reset_in_sfd();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
